// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry.
// Used by both the transmitter and the matching receiver.
package uart_pkg;

  // 2-bit FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // 8N1 frame: start + 8 data + stop
  localparam int unsigned FRAME_BITS = 10;

  // Number of clock cycles one complete frame occupies on the line
  function automatic int unsigned frame_cycles(input int unsigned clks_per_bit);
    return FRAME_BITS * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps. The terminal-count
// pulse marks the last cycle of a bit. Restart holds the counter at 0 so the
// next bit period starts from a clean boundary.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tc
);

  localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  assign tc = (count_q == LAST_COUNT);

  // Next count: wrap at the bit boundary or when restarted
  always_comb begin
    count_d = count_q + 16'd1;
    if (restart || tc) begin
      count_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register so the next byte
// can be accepted while the current one is shifting out.
//
// Handshake: a byte is taken on a rising edge where tx_valid and tx_ready are
// both high. tx_ready is simply "holding register empty"; tx_valid while
// tx_ready is low is ignored and tx_data is only looked at on acceptance.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  logic [1:0]           state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 take;
  logic                 accept;
  logic                 bit_tc;
  logic                 baud_restart;

  // Counter is held at zero while idle so the start bit gets a full period
  assign baud_restart = (state_q == ST_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(baud_restart),
    .tc     (bit_tc)
  );

  assign tx_ready  = ~hold_full_q;
  assign accept    = tx_valid & tx_ready;
  assign tx        = tx_q;
  assign busy      = (state_q != ST_IDLE) | hold_full_q;
  assign dbg_state = state_q;

  // Frame sequencing; tx_d is the line level for the state being entered,
  // so tx stays a pure register output
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    take      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          state_d = ST_START;
          take    = 1'b1;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_tc) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_tc) begin
          if (bit_idx_q == LAST_IDX) begin
            state_d   = ST_STOP;
            bit_idx_d = '0;
            tx_d      = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (bit_tc) begin
          if (hold_full_q) begin
            // Chain straight into the next frame, no idle gap
            state_d = ST_START;
            take    = 1'b1;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (take) begin
      shift_d = hold_q;
    end
  end

  // Holding register: fill on acceptance, empty on transfer to the shifter
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = (hold_full_q & ~take) | accept;
    if (accept) begin
      hold_d = tx_data;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: a line decoder rebuilds each frame from tx samples
// and compares it with the bytes handed over by the handshake.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB_A = 4;
  localparam int CPB_B = 2;
  localparam int FLEN_A = FRAME_BITS * CPB_A;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] tx_data_a = '0;
  logic       tx_valid_a = 1'b0;
  logic       tx_ready_a, tx_a, busy_a;
  logic [1:0] state_a;

  logic [7:0] tx_data_b = '0;
  logic       tx_valid_b = 1'b0;
  logic       tx_ready_b, tx_b, busy_b;
  logic [1:0] state_b;

  uart_tx #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8)) dut_a (
    .clk(clk), .reset(reset), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .tx(tx_a), .busy(busy_a), .dbg_state(state_a)
  );

  uart_tx #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(8)) dut_b (
    .clk(clk), .reset(reset), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .tx(tx_b), .busy(busy_b), .dbg_state(state_b)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- line monitor (DUT A) ----------------
  logic samp [0:FLEN_A-1];
  int   nsamp = 0;
  bit   in_frame = 0;
  int   cur_idx = 0;
  int   frames_started = 0;
  int   frames_done = 0;
  int   busy_low_cnt = 0;
  int   acc_cyc = 0;
  int   fr_start [0:127];
  int   fr_end [0:127];

  task automatic decode_frame();
    int bad = 0;
    logic [7:0] b = '0;
    for (int k = 0; k < FRAME_BITS; k++)
      for (int j = 1; j < CPB_A; j++)
        if (samp[k*CPB_A+j] !== samp[k*CPB_A]) bad++;
    for (int k = 0; k < 8; k++) b[k] = samp[(k+1)*CPB_A];
    check_eq("bit_width", bad, 0);
    check_eq("stop_bit", samp[9*CPB_A], 1);
    if (exp_q.size() == 0) check_eq("frame_has_expected", exp_q.size(), 1);
    else check_eq("frame_byte", b, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (reset) begin
      in_frame = 0;
      nsamp = 0;
      exp_q.delete();
    end else begin
      if (!in_frame && tx_a == 1'b0) begin
        in_frame = 1;
        nsamp = 0;
        cur_idx = frames_started % 128;
        fr_start[cur_idx] = cyc;
        frames_started++;
      end
      if (in_frame) begin
        samp[nsamp] = tx_a;
        nsamp++;
        if (!busy_a) busy_low_cnt++;
        if (nsamp == FLEN_A) begin
          decode_frame();
          fr_end[cur_idx] = cyc;
          frames_done++;
          in_frame = 0;
        end
      end
      // Byte offered now is taken on the coming rising edge
      if (tx_valid_a && tx_ready_a) begin
        exp_q.push_back(tx_data_a);
        acc_cyc = cyc + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_a(input logic [7:0] b);
    int waited = 0;
    @(posedge clk); #1;
    tx_data_a = b;
    tx_valid_a = 1'b1;
    while (!tx_ready_a && waited < 400) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("send_accepted", (waited < 400) ? 1 : 0, 1);
    @(posedge clk); #1;
    tx_valid_a = 1'b0;
  endtask

  task automatic wait_started(input int n);
    int t = 0;
    while (frames_started < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_eq("frames_started", frames_started, n);
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (frames_done < n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check_eq("frames_done", frames_done, n);
  endtask

  task automatic check_idle_a(input string tag);
    @(negedge clk);
    check_eq({tag, "_tx"}, tx_a, 1);
    check_eq({tag, "_busy"}, busy_a, 0);
    check_eq({tag, "_state"}, state_a, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int t;
    logic [7:0] hold_bytes [0:2];
    logic [7:0] bb;
    int bitn;
    int e;

    // Reset values
    @(negedge clk);
    check_eq("rst_tx", tx_a, 1);
    check_eq("rst_ready", tx_ready_a, 1);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_state", state_a, ST_IDLE);
    check_eq("rst_b_tx", tx_b, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single byte from idle
    send_a(8'h55);
    wait_started(1);
    check_eq("start_latency", fr_start[0], acc_cyc + 1);
    wait_done(1);
    check_idle_a("after_55");

    // Back-to-back: second byte held during first frame
    send_a(8'hA3);
    send_a(8'h0F);
    wait_done(3);
    check_eq("b2b_gap", fr_start[2], fr_end[1] + 1);
    check_eq("b2b_span", fr_end[2] - fr_start[1] + 1, 2 * frame_cycles(CPB_A));
    check_idle_a("after_b2b");

    // tx_valid held high across three bytes
    hold_bytes[0] = 8'h11; hold_bytes[1] = 8'h22; hold_bytes[2] = 8'h33;
    n = 0; t = 0;
    @(posedge clk); #1;
    tx_data_a = hold_bytes[0];
    tx_valid_a = 1'b1;
    while (n < 3 && t < 400) begin
      if (tx_ready_a) begin
        @(posedge clk); #1;
        n++;
        if (n == 2) check_eq("ready_after_2nd", tx_ready_a, 0);
        if (n < 3) tx_data_a = hold_bytes[n];
      end else begin
        @(posedge clk); #1;
        t++;
      end
    end
    tx_valid_a = 1'b0;
    check_eq("hold_accepts", n, 3);
    wait_done(6);
    repeat (50) @(negedge clk);
    check_eq("hold_frames", frames_started, 6);
    check_eq("hold_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a 0xFF frame
    send_a(8'hFF);
    wait_started(7);
    repeat (15) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_tx", tx_a, 1);
    check_eq("midrst_ready", tx_ready_a, 1);
    check_eq("midrst_busy", busy_a, 0);
    check_eq("midrst_done", frames_done, 6);
    send_a(8'h00);
    wait_done(7);

    // Reset wins over a simultaneous offer
    @(posedge clk); #1;
    reset = 1'b1;
    tx_valid_a = 1'b1;
    tx_data_a = 8'h5A;
    @(posedge clk); #1;
    reset = 1'b0;
    tx_valid_a = 1'b0;
    @(negedge clk);
    check_eq("rstacc_ready", tx_ready_a, 1);
    check_eq("rstacc_busy", busy_a, 0);
    repeat (50) @(negedge clk);
    check_eq("rstacc_no_frame", frames_started, 8);

    // tx_data churn after acceptance
    send_a(8'hC6);
    repeat (45) begin
      @(posedge clk); #1;
      tx_data_a = 8'($urandom);
    end
    wait_done(8);

    // Random bytes with random spacing
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 50)) @(posedge clk);
      send_a(8'($urandom));
    end
    wait_done(28);
    check_idle_a("after_random");
    check_eq("final_queue_empty", exp_q.size(), 0);
    check_eq("busy_in_frame", busy_low_cnt, 0);

    // Minimum bit period on the second instance
    bb = 8'h80;
    @(posedge clk); #1;
    check_eq("b_ready", tx_ready_b, 1);
    tx_data_b = bb;
    tx_valid_b = 1'b1;
    @(posedge clk); #1;
    tx_valid_b = 1'b0;
    @(negedge clk);
    check_eq("b_pre_start", tx_b, 1);
    for (int k = 0; k < FRAME_BITS * CPB_B; k++) begin
      @(negedge clk);
      bitn = k / CPB_B;
      if (bitn == 0) e = 0;
      else if (bitn == 9) e = 1;
      else e = bb[bitn-1];
      check_eq("b_line", tx_b, e);
    end
    @(negedge clk);
    check_eq("b_end_tx", tx_b, 1);
    check_eq("b_end_busy", busy_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop if something stalls beyond all per-wait budgets
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
